nanov_serial_exec: RTL and testbench

Parametrised digit-serial integer execution unit for nanoV: holds the register file and executes RV32E OP / OP-IMM ALU instructions plus store-data capture, DIGIT bits per cycle, LSB first. It is the next generation of the 1-bit serial ALU/register path. It adds:
- configurable datapath width, digit width and register count;
- a valid/ready instruction handshake and a pause input;
- a debug read port for verification.

---
 rtl/nanov_serial_exec.sv | 270 +++++++++++++++++++++++++++
 tb/tb_nanov_serial_exec.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_serial_exec.sv
// nanov_serial_exec: digit-serial RV32E OP / OP-IMM execution unit with its
// own register file. Each instruction is processed DIGIT bits per cycle,
// LSB first. Compares need one extra cycle to write the final result bit.
module nanov_serial_exec #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 1,
  parameter int NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     instr_valid,
  input  logic [31:0]              instr,
  output logic                     instr_ready,
  input  logic                     pause,
  output logic                     done,
  output logic [XLEN-1:0]          store_data,
  output logic                     store_valid,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  localparam int N  = XLEN / DIGIT;
  localparam int RB = $clog2(NREGS);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_SLTFIX = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_SLT  = 3'd3,
    OP_SLTU = 3'd4,
    OP_XOR  = 3'd5,
    OP_OR   = 3'd6,
    OP_AND  = 3'd7
  } alu_t;

  // Architectural and control state
  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                cmp_q, cmp_d;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [RB-1:0]       rd_q, rd_d;
  logic [RB-1:0]       rs1_q, rs1_d;
  logic [RB-1:0]       rs2_q, rs2_d;
  logic [XLEN-1:0]     imm_q, imm_d;
  logic                use_imm_q, use_imm_d;
  alu_t                alu_q, alu_d;
  logic                store_q, store_d;
  logic [XLEN-1:0]     store_data_q, store_data_d;
  logic                done_q, done_d;
  logic                store_valid_q, store_valid_d;
  logic                ready_q, ready_d;

  // Datapath intermediates
  logic [XLEN-1:0]     a_word_s, rs2_word_s, b_word_s;
  logic [DIGIT-1:0]    a_dig_s, b_dig_s, bx_dig_s, rs2_dig_s, res_dig_s;
  logic [DIGIT:0]      sum_s;
  logic                inv_s, cin_s, cmp_bit_s, is_cmp_s;
  int                  base_s;

  // Decode intermediates
  logic [6:0]          dec_opc_s;
  logic [2:0]          dec_f3_s;
  logic                dec_is_alu_s;
  alu_t                dec_alu_s;

  // Bits of instr beyond the decoded fields are intentionally ignored
  logic                unused_instr_s;
  assign unused_instr_s = ^instr;

  assign instr_ready = ready_q;
  assign done        = done_q;
  assign store_valid = store_valid_q;
  assign store_data  = store_data_q;
  assign dbg_data    = (dbg_addr == {RB{1'b0}}) ? {XLEN{1'b0}} : regs_q[dbg_addr];

  // Decode the incoming instruction word into an ALU operation
  always_comb begin
    dec_opc_s    = instr[6:0];
    dec_f3_s     = instr[14:12];
    dec_is_alu_s = (dec_opc_s == OPC_OPIMM) || (dec_opc_s == OPC_OP);
    dec_alu_s    = OP_NONE;
    if (dec_is_alu_s) begin
      case (dec_f3_s)
        3'b000:  dec_alu_s = ((dec_opc_s == OPC_OP) && instr[30]) ? OP_SUB : OP_ADD;
        3'b010:  dec_alu_s = OP_SLT;
        3'b011:  dec_alu_s = OP_SLTU;
        3'b100:  dec_alu_s = OP_XOR;
        3'b110:  dec_alu_s = OP_OR;
        3'b111:  dec_alu_s = OP_AND;
        default: dec_alu_s = OP_NONE;
      endcase
    end else begin
      dec_alu_s = OP_NONE;
    end
  end

  // Select the current source digits and compute one digit of the result
  always_comb begin
    base_s     = int'(cnt_q) * DIGIT;
    a_word_s   = (rs1_q == {RB{1'b0}}) ? {XLEN{1'b0}} : regs_q[rs1_q];
    rs2_word_s = (rs2_q == {RB{1'b0}}) ? {XLEN{1'b0}} : regs_q[rs2_q];
    b_word_s   = use_imm_q ? imm_q : rs2_word_s;
    a_dig_s    = a_word_s[base_s +: DIGIT];
    b_dig_s    = b_word_s[base_s +: DIGIT];
    rs2_dig_s  = rs2_word_s[base_s +: DIGIT];
    is_cmp_s   = (alu_q == OP_SLT) || (alu_q == OP_SLTU);
    inv_s      = (alu_q == OP_SUB) || is_cmp_s;
    bx_dig_s   = inv_s ? ~b_dig_s : b_dig_s;
    // carry-in at digit 0 is the subtract injection; afterwards the stored carry
    cin_s      = (cnt_q == {CW{1'b0}}) ? inv_s : carry_q;
    sum_s      = {1'b0, a_dig_s} + {1'b0, bx_dig_s} + {{DIGIT{1'b0}}, cin_s};
    case (alu_q)
      OP_XOR:  res_dig_s = a_dig_s ^ b_dig_s;
      OP_OR:   res_dig_s = a_dig_s | b_dig_s;
      OP_AND:  res_dig_s = a_dig_s & b_dig_s;
      default: res_dig_s = sum_s[DIGIT-1:0];
    endcase
    // only meaningful on the most significant digit
    if (alu_q == OP_SLTU) begin
      cmp_bit_s = ~sum_s[DIGIT];
    end else if (a_dig_s[DIGIT-1] != b_dig_s[DIGIT-1]) begin
      cmp_bit_s = a_dig_s[DIGIT-1];
    end else begin
      cmp_bit_s = sum_s[DIGIT-1];
    end
  end

  // Sequencing: accept, digit-serial execution, compare write-back
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    carry_d       = carry_q;
    cmp_d         = cmp_q;
    regs_d        = regs_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    use_imm_d     = use_imm_q;
    alu_d         = alu_q;
    store_d       = store_q;
    store_data_d  = store_data_q;
    done_d        = 1'b0;
    store_valid_d = 1'b0;
    ready_d       = ready_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d   = S_EXEC;
          cnt_d     = {CW{1'b0}};
          carry_d   = 1'b0;
          rd_d      = instr[7 +: RB];
          rs1_d     = instr[15 +: RB];
          rs2_d     = instr[20 +: RB];
          imm_d     = {{(XLEN-12){instr[31]}}, instr[31:20]};
          use_imm_d = (dec_opc_s == OPC_OPIMM);
          alu_d     = dec_alu_s;
          store_d   = (dec_opc_s == OPC_STORE);
          ready_d   = 1'b0;
        end else begin
          ready_d   = 1'b1;
        end
      end
      S_EXEC: begin
        if (!pause) begin
          // sources for this digit are read from regs_q before rd is updated
          if ((alu_q != OP_NONE) && !is_cmp_s && (rd_q != {RB{1'b0}})) begin
            regs_d[rd_q][base_s +: DIGIT] = res_dig_s;
          end else begin
            regs_d = regs_q;
          end
          if (store_q) begin
            store_data_d[base_s +: DIGIT] = rs2_dig_s;
          end else begin
            store_data_d = store_data_q;
          end
          carry_d = sum_s[DIGIT];
          if (cnt_q == LAST_DIGIT) begin
            cnt_d = {CW{1'b0}};
            cmp_d = cmp_bit_s;
            if (is_cmp_s) begin
              state_d = S_SLTFIX;
            end else begin
              state_d       = S_IDLE;
              done_d        = 1'b1;
              store_valid_d = store_q;
              ready_d       = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_SLTFIX: begin
        if (!pause) begin
          if (rd_q != {RB{1'b0}}) begin
            regs_d[rd_q] = {{(XLEN-1){1'b0}}, cmp_q};
          end else begin
            regs_d = regs_q;
          end
          state_d = S_IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = S_SLTFIX;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers; reset clears the register file and abandons any instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= {CW{1'b0}};
      carry_q       <= 1'b0;
      cmp_q         <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= {XLEN{1'b0}};
      rd_q          <= {RB{1'b0}};
      rs1_q         <= {RB{1'b0}};
      rs2_q         <= {RB{1'b0}};
      imm_q         <= {XLEN{1'b0}};
      use_imm_q     <= 1'b0;
      alu_q         <= OP_NONE;
      store_q       <= 1'b0;
      store_data_q  <= {XLEN{1'b0}};
      done_q        <= 1'b0;
      store_valid_q <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      carry_q       <= carry_d;
      cmp_q         <= cmp_d;
      regs_q        <= regs_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      use_imm_q     <= use_imm_d;
      alu_q         <= alu_d;
      store_q       <= store_d;
      store_data_q  <= store_data_d;
      done_q        <= done_d;
      store_valid_q <= store_valid_d;
      ready_q       <= ready_d;
    end
  end

endmodule

// File: tb/tb_nanov_serial_exec.sv
// Directed self-checking bench for nanov_serial_exec. A plain-arithmetic
// reference model tracks the register file, store data and latency.
module tb_nanov_serial_exec;

  localparam int TB_DIGIT = 1;
  localparam int N        = 32 / TB_DIGIT;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        pause;
  logic        done;
  logic [31:0] store_data;
  logic        store_valid;
  logic [3:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mregs [16];
  logic [31:0] m_store;

  nanov_serial_exec #(.XLEN(32), .DIGIT(TB_DIGIT), .NREGS(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pause       (pause),
    .done        (done),
    .store_data  (store_data),
    .store_valid (store_valid),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Reference model: architectural effect of one instruction
  task automatic model_step(input logic [31:0] ins, output bit is_store,
                            output logic [31:0] st, output int lat);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] a, b, r;
    bit          alu, wr, cmp;
    opc = ins[6:0];
    f3  = ins[14:12];
    a   = mregs[ins[18:15]];
    alu = (opc == 7'b0010011) || (opc == 7'b0110011);
    b   = (opc == 7'b0110011) ? mregs[ins[23:20]] : {{20{ins[31]}}, ins[31:20]};
    cmp = alu && ((f3 == 3'b010) || (f3 == 3'b011));
    wr  = alu;
    r   = 32'h0;
    case (f3)
      3'b000:  r = ((opc == 7'b0110011) && ins[30]) ? a - b : a + b;
      3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  r = (a < b) ? 32'd1 : 32'd0;
      3'b100:  r = a ^ b;
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: wr = 1'b0;
    endcase
    if (wr && (ins[10:7] != 4'd0)) mregs[ins[10:7]] = r;
    is_store = (opc == 7'b0100011);
    if (is_store) m_store = mregs[ins[23:20]];
    st  = m_store;
    lat = N + 1 + (cmp ? 1 : 0);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("reg_x%0d", i), dbg_data, mregs[i]);
    end
    check("store_data_hold", store_data, m_store);
  endtask

  task automatic lit(input logic [3:0] addr, input logic [31:0] exp, input string name);
    dbg_addr = addr;
    #1;
    check(name, dbg_data, exp);
  endtask

  // Issue one instruction, optionally pausing, and check its retirement
  task automatic run(input logic [31:0] ins, input int pause_at, input int pause_len);
    int          cyc;
    bit          got;
    bit          is_store;
    logic [31:0] st;
    int          lat;
    @(negedge clk);
    check("ready_before_accept", 32'(instr_ready), 32'd1);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    cyc = 1;
    got = 1'b0;
    while (cyc < 4 * N + 20) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      pause = (cyc >= pause_at) && (cyc < pause_at + pause_len);
      @(posedge clk);
      cyc++;
    end
    pause = 1'b0;
    model_step(ins, is_store, st, lat);
    if (!got) check("done_timeout", 32'd0, 32'd1);
    else      check("latency", 32'(cyc), 32'(lat + pause_len));
    check("store_valid", 32'(store_valid), 32'(is_store));
    if (is_store) check("store_data", store_data, st);
    @(negedge clk);
    check("done_pulse_end", 32'(done), 32'd0);
    check_regs();
  endtask

  // Output relations that must hold whenever a retirement is signalled
  always @(negedge clk) begin
    if (rstn && (done || store_valid)) begin
      check("done_with_ready", 32'(instr_ready), 32'd1);
      check("store_valid_needs_done", 32'(done), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    pause       = 1'b0;
    dbg_addr    = 4'd0;
    m_store     = 32'h0;
    for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
    #12;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_store_valid", 32'(store_valid), 32'd0);
    check("rst_store_data", store_data, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    check_regs();

    // ADDI x1,x0,5 ; ADDI x2,x1,-7
    run(itype(12'd5, 5'd0, 3'b000, 5'd1), 0, 0);
    run(itype(12'hFF9, 5'd1, 3'b000, 5'd2), 0, 0);
    lit(4'd1, 32'd5, "lit_x1");
    lit(4'd2, 32'hFFFFFFFE, "lit_x2");
    // SUB x3,x1,x2
    run(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3), 0, 0);
    lit(4'd3, 32'd7, "lit_sub");
    // AND / OR x4,x1,x2
    run(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd4), 0, 0);
    lit(4'd4, 32'h4, "lit_and");
    run(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd4), 0, 0);
    lit(4'd4, 32'hFFFFFFFF, "lit_or");
    // ADD wrap: x9 = 0xFFFFFFFF + 1
    run(itype(12'd1, 5'd0, 3'b000, 5'd8), 0, 0);
    run(rtype(7'h00, 5'd8, 5'd4, 3'b000, 5'd9), 0, 0);
    lit(4'd9, 32'h0, "lit_add_wrap");
    run(rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd4), 0, 0);
    lit(4'd4, 32'hFFFFFFFB, "lit_xor");
    // compares
    run(rtype(7'h00, 5'd1, 5'd2, 3'b010, 5'd5), 0, 0);
    lit(4'd5, 32'd1, "lit_slt");
    run(rtype(7'h00, 5'd1, 5'd2, 3'b011, 5'd5), 0, 0);
    lit(4'd5, 32'd0, "lit_sltu");
    run(itype(12'hFFF, 5'd1, 3'b011, 5'd10), 0, 0);
    lit(4'd10, 32'd1, "lit_sltiu_sext");
    run(itype(12'h000, 5'd2, 3'b010, 5'd2), 0, 0);
    lit(4'd2, 32'd1, "lit_slti_rd_eq_rs1");
    // OP-IMM ignores bit 30; x0 writes suppressed; shifts and LUI do nothing
    run(itype(12'h400, 5'd1, 3'b000, 5'd14), 0, 0);
    lit(4'd14, 32'h405, "lit_addi_bit30");
    run(itype(12'd9, 5'd0, 3'b000, 5'd0), 0, 0);
    lit(4'd0, 32'h0, "lit_x0");
    run(itype(12'd1, 5'd1, 3'b001, 5'd12), 0, 0);
    run({20'h12345, 5'd12, 7'b0110111}, 0, 0);
    lit(4'd12, 32'h0, "lit_no_write");

    // Build 0xDEADBEEF in x6 by doubling, then STORE it
    run(itype(12'h37A, 5'd0, 3'b000, 5'd6), 0, 0);
    for (int i = 0; i < 11; i++) run(rtype(7'h00, 5'd6, 5'd6, 3'b000, 5'd6), 0, 0);
    run(itype(12'h5B7, 5'd0, 3'b000, 5'd7), 0, 0);
    run(rtype(7'h00, 5'd7, 5'd6, 3'b110, 5'd6), 0, 0);
    for (int i = 0; i < 11; i++) run(rtype(7'h00, 5'd6, 5'd6, 3'b000, 5'd6), 0, 0);
    run(itype(12'h6EF, 5'd0, 3'b000, 5'd7), 0, 0);
    run(rtype(7'h00, 5'd7, 5'd6, 3'b110, 5'd6), 0, 0);
    lit(4'd6, 32'hDEADBEEF, "lit_build");
    run({7'h00, 5'd6, 5'd0, 3'b010, 5'd0, 7'b0100011}, 0, 0);
    check("lit_store_data", store_data, 32'hDEADBEEF);

    // ADD with 3 paused cycles mid-execution
    run(rtype(7'h00, 5'd3, 5'd1, 3'b000, 5'd11), 5, 3);
    lit(4'd11, 32'd12, "lit_paused_add");
    // SLT with pause straddling the compare fix-up cycle
    run(rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd13), N, 2);

    // Reset in the middle of an ADD
    @(negedge clk);
    instr       = rtype(7'h00, 5'd3, 5'd1, 3'b000, 5'd13);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (N / 2) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_ready", 32'(instr_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_store_data", store_data, 32'h0);
    for (int i = 0; i < 16; i++) mregs[i] = 32'h0;
    m_store = 32'h0;
    check_regs();
    @(negedge clk);
    rstn = 1'b1;
    run(itype(12'd3, 5'd0, 3'b000, 5'd1), 0, 0);
    lit(4'd1, 32'd3, "lit_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
